pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 320, width of the datapath payload (PC, PC offset, two operands, immediate).
REQ-002 Parameter CTRL_W, default 14, width of the control word.
REQ-003 Parameter IDX_W, default 15, width of the register-index field (rs1, rs2, rd).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset.
REQ-006 Port in_valid  input  1  upstream stage offers a transfer.
REQ-007 Port in_ready  output  1  stage can accept a transfer this cycle.
REQ-008 Port in_data / in_idx / in_ctrl  input  DATA_W / IDX_W / CTRL_W  upstream payload.
REQ-009 Port flush  input  1  squash all held entries (branch mispredict / exception).
REQ-010 Port out_valid  output  1  downstream transfer offered.
REQ-011 Port out_ready  input  1  downstream stage accepts.
REQ-012 Port out_data / out_idx / out_ctrl  output  DATA_W / IDX_W / CTRL_W  downstream payload.
REQ-013 Port occ  output  2  number of held entries, 0..2.

Function
REQ-014 push = in_valid & in_ready; pop = out_valid & out_ready; each completes on the rising edge.
REQ-015 Storage is two entries: main (drives outputs) and skid.
REQ-016 States: EMPTY (occ 0), BUSY (main valid, occ 1), FULL (main+skid valid, occ 2).
REQ-017 in_ready is 1 in EMPTY and BUSY and 0 in FULL, decoded from state registers only, with no combinational path from out_ready.
REQ-018 out_valid is 1 in BUSY and FULL and 0 in EMPTY.
REQ-019 EMPTY: on push, main <= in, go to BUSY; otherwise stay.
REQ-020 BUSY: push&pop -> main <= in, stay BUSY; push only -> skid <= in, go to FULL; pop only -> go to EMPTY; neither -> hold.
REQ-021 FULL: on pop, main <= skid, go to BUSY; otherwise hold; no push is possible.
REQ-022 Latency is 1 cycle from push to out_valid when EMPTY, and throughput is 1 transfer per cycle with out_ready held high.
REQ-023 Entries leave in strict FIFO order, with none lost or duplicated.
REQ-024 out_ctrl shall be all-zero whenever out_valid=0, so that a bubble carries no side effects.
REQ-025 flush=1: next state is EMPTY, and a push or pop in the same cycle is discarded with no effect on state.
REQ-026 flush has priority over push and pop, and over reset-released operation, in every state.
REQ-027 out_data and out_idx hold their last value while out_valid=0, and stay stable while out_valid=1 and out_ready=0.

Reset
REQ-028 With reset=0 at a rising edge, state becomes EMPTY and main, skid, out_data, out_idx and out_ctrl become 0.
REQ-029 After that reset edge, in_ready=1, out_valid=0 and occ=0.
REQ-030 Reset asserted mid-transfer drops all held entries, with reset taking priority over flush.
REQ-031 Reset has no effect between clock edges.

Structure
REQ-032 A shared pipeline package holds the state enum (EMPTY/BUSY/FULL) and the default-width constants DATA_W, CTRL_W and IDX_W.
REQ-033 One sub-module, pipe_entry, shall be used: a parametrised enable-loaded register of DATA_W+IDX_W+CTRL_W bits, instantiated twice for main and skid.
REQ-034 Control logic is a single next-state/load-select block.

Verification
REQ-035 Reset, then in_valid=1 with data 0x1 for 1 cycle, out_ready=1 -> out_valid=1 with out_data=0x1 on the next cycle, then occ=0.
REQ-036 Stream values 1..8 back-to-back with out_ready=1 -> 8 outputs in order on consecutive cycles, in_ready constantly 1.
REQ-037 out_ready=0 while pushing A, B, C -> A in main, B in skid, occ=2, in_ready=0, C held upstream; raise out_ready -> outputs A, B, C in order.
REQ-038 FULL with flush=1 and in_valid=1 -> next cycle occ=0, out_valid=0, out_ctrl=0, and the flushed input is never output.
REQ-039 FULL, then reset=0 for 1 cycle with out_ready=1 -> EMPTY with all outputs 0, and nothing popped.
REQ-040 BUSY with push and pop in the same cycle, repeated 5 times -> occ stays 1 and the output sequence matches the input sequence.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the two-entry skid pipeline stage: default payload
// widths, the occupancy state encoding and a state-to-count helper.
package pipe_stage_reg_pkg;

  localparam int DATA_W = 320;
  localparam int CTRL_W = 14;
  localparam int IDX_W  = 15;

  // The encoding equals the number of held entries, so occupancy decodes
  // straight from the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] n;
    case (s)
      BUSY:    n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload slot of the pipeline stage: a register that loads when enabled
// and clears on synchronous active-low reset.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Payload slot: clear on reset, capture on load, otherwise hold.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values and simulation ordering cannot change the result.
  // NOTE: the payload is reset (not left uninitialised like a RAM) because
  // out_data/out_idx must read zero straight after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline register with valid/ready handshakes on
// both sides. in_ready comes from the state register only, so there is no
// combinational path from out_ready to in_ready. flush squashes all held
// entries; reset outranks flush.
module pipe_stage_reg #(
  parameter int DATA_W = pipe_stage_reg_pkg::DATA_W,
  parameter int CTRL_W = pipe_stage_reg_pkg::CTRL_W,
  parameter int IDX_W  = pipe_stage_reg_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  import pipe_stage_reg_pkg::*;

  localparam int ENT_W = DATA_W + IDX_W + CTRL_W;

  state_e             state_q, state_d;
  logic               push, pop;
  logic               load_main, load_skid, main_from_skid;
  logic [ENT_W-1:0]   in_ent, main_d, main_q, skid_q;
  logic [CTRL_W-1:0]  main_ctrl;

  assign in_ent    = {in_data, in_idx, in_ctrl};
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next state and load selects for the main and skid slots.
  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            load_main = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (push) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_ent;

  // Occupancy state register; reset outranks flush and normal operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_entry #(.W(ENT_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load_i (load_main),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_entry #(.W(ENT_W)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load_i (load_skid),
    .d_i    (in_ent),
    .q_o    (skid_q)
  );

  // Data and index keep their last value through bubbles; control is gated
  // so a bubble never carries side effects downstream.
  assign {out_data, out_idx, main_ctrl} = main_q;
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign occ      = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. The driver pushes each accepted input's
// expected payload into a scoreboard queue; a separate monitor pops and
// compares on every downstream transfer and checks bubble and stall rules.
module tb_pipe_stage_reg;

  localparam int DATA_W = 320;
  localparam int CTRL_W = 14;
  localparam int IDX_W  = 15;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic [CTRL_W-1:0] ctrl;
  } pl_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_idx;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occ;

  int  n_cmp  = 0;
  int  n_fail = 0;
  int  n_out  = 0;
  pl_t sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_idx    (in_idx),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_ctrl  (out_ctrl),
    .occ       (occ)
  );

  function automatic pl_t mk(input logic [31:0] v);
    pl_t p;
    p.data = {10{v}};
    p.idx  = 15'(v * 3 + 1);
    p.ctrl = 14'h2000 | 14'(v);
    return p;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of upstream stimulus; record the payload if it will be
  // accepted at the coming edge (in_ready is state-only, so known now).
  task automatic drive(input logic v, input logic [31:0] val, input logic f);
    pl_t p;
    p        = mk(val);
    in_valid = v;
    in_data  = p.data;
    in_idx   = p.idx;
    in_ctrl  = p.ctrl;
    flush    = f;
    if (v && in_ready && !f && reset) sb.push_back(p);
  endtask

  // Monitor: compares transfers against the scoreboard, checks that bubbles
  // carry zero control and that a stalled output stays stable.
  logic prev_stall = 1'b0;
  pl_t  prev_pl;
  always @(negedge clk) begin
    pl_t got;
    pl_t exp;
    got = '{data: out_data, idx: out_idx, ctrl: out_ctrl};
    if (!out_valid) check("bubble_ctrl_zero", DATA_W'(out_ctrl), '0);
    if (prev_stall && out_valid) check("stall_stable", got, prev_pl);
    if (!reset || flush) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected nothing", got.data);
      end else begin
        exp = sb.pop_front();
        check("sb_data", got.data, exp.data);
        check("sb_idx", DATA_W'(got.idx), DATA_W'(exp.idx));
        check("sb_ctrl", DATA_W'(got.ctrl), DATA_W'(exp.ctrl));
      end
    end
    prev_stall = out_valid && !out_ready && reset && !flush;
    prev_pl    = got;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int out_before;
    reset     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    tick();
    reset = 1'b1;

    // Reset state.
    check("rst_occ", DATA_W'(occ), 0);
    check("rst_in_ready", DATA_W'(in_ready), 1);
    check("rst_out_valid", DATA_W'(out_valid), 0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ctrl", DATA_W'(out_ctrl), 0);

    // Single transfer: one-cycle latency, then empty with data held.
    out_ready = 1'b1;
    drive(1'b1, 1, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0);
    check("t1_out_valid", DATA_W'(out_valid), 1);
    check("t1_out_data", out_data, mk(1).data);
    tick();
    check("t1_occ_after", DATA_W'(occ), 0);
    check("t1_hold_data", out_data, mk(1).data);

    // Back-to-back stream 1..8 at full throughput.
    out_before = n_out;
    for (int v = 1; v <= 8; v++) begin
      check("s_in_ready", DATA_W'(in_ready), 1);
      drive(1'b1, 32'(v), 1'b0);
      tick();
      check("s_out_data", out_data, mk(32'(v)).data);
      check("s_occ", DATA_W'(occ), 1);
    end
    drive(1'b0, 0, 1'b0);
    tick();
    check("s_count", DATA_W'(n_out - out_before), 8);

    // Backpressure: A main, B skid, C held upstream; then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0);
    tick();
    check("bp_occ_full", DATA_W'(occ), 2);
    check("bp_in_ready", DATA_W'(in_ready), 0);
    check("bp_main_a", out_data, mk(32'hA).data);
    drive(1'b1, 32'hC, 1'b0);
    tick();
    check("bp_still_full", DATA_W'(occ), 2);
    out_ready = 1'b1;
    drive(1'b1, 32'hC, 1'b0);
    tick();
    check("bp_out_b", out_data, mk(32'hB).data);
    drive(1'b1, 32'hC, 1'b0);
    tick();
    check("bp_out_c", out_data, mk(32'hC).data);
    drive(1'b0, 0, 1'b0);
    tick();
    check("bp_empty", DATA_W'(occ), 0);

    // Flush from FULL with a concurrent push.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b0);
    tick();
    drive(1'b1, 32'h12, 1'b0);
    tick();
    drive(1'b1, 32'h13, 1'b1);
    tick();
    drive(1'b0, 0, 1'b0);
    check("fl_occ", DATA_W'(occ), 0);
    check("fl_out_valid", DATA_W'(out_valid), 0);
    check("fl_out_ctrl", DATA_W'(out_ctrl), 0);
    out_ready = 1'b1;
    tick();
    tick();
    check("fl_no_output", DATA_W'(out_valid), 0);

    // Reset from FULL with out_ready high: nothing popped, all cleared.
    out_ready = 1'b0;
    drive(1'b1, 32'h21, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0);
    out_before = n_out;
    out_ready  = 1'b1;
    reset      = 1'b0;
    tick();
    reset = 1'b1;
    check("mr_occ", DATA_W'(occ), 0);
    check("mr_out_valid", DATA_W'(out_valid), 0);
    check("mr_in_ready", DATA_W'(in_ready), 1);
    check("mr_out_data", out_data, '0);
    check("mr_out_idx", DATA_W'(out_idx), 0);
    check("mr_out_ctrl", DATA_W'(out_ctrl), 0);
    check("mr_no_pop", DATA_W'(n_out - out_before), 0);

    // BUSY with simultaneous push and pop, five times.
    out_ready = 1'b0;
    drive(1'b1, 32'h30, 1'b0);
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 32'(32'h30 + k), 1'b0);
      tick();
      check("pp_occ", DATA_W'(occ), 1);
      check("pp_out_data", out_data, mk(32'(32'h30 + k)).data);
    end
    drive(1'b0, 0, 1'b0);
    tick();
    check("pp_empty", DATA_W'(occ), 0);

    tick();
    tick();
    check("sb_drained", DATA_W'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
